// File: rtl/z80_io_bus_initiator.sv
// Turns each Z80 slot I/O cycle into one peripheral-bus beat and holds WAIT low until it completes.
// Read path: start at N, bus_valid at N+1, data back on the slot by N+3; bus_ready low keeps bus_valid up.
module z80_io_bus_initiator #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          TIMEOUT_BITS   = 8,
  parameter logic [7:0]  OPEN_BUS_DATA  = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       z80_iorq_n,
  input  logic       z80_rd_n,
  input  logic       z80_wr_n,
  input  logic       z80_m1_n,
  input  logic [7:0] z80_address,
  input  logic [7:0] z80_wdata,
  output logic       z80_wait_n,
  output logic [7:0] z80_rdata,
  output logic       z80_rdata_en,
  output logic       bus_ioreq,
  output logic [7:0] bus_address,
  output logic       bus_write,
  output logic       bus_valid,
  input  logic       bus_ready,
  output logic [7:0] bus_wdata,
  input  logic [7:0] bus_rdata,
  input  logic       bus_rdata_en
);

  typedef enum logic [1:0] {IDLE, REQ, RDWAIT, HOLD} state_t;

  localparam logic [TIMEOUT_BITS-1:0] TIMEOUT_LAST = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);

  state_t                  state;
  logic [TIMEOUT_BITS-1:0] timeout_cnt;
  logic                    start;

  // Interrupt acknowledge (M1 with IORQ) is not a peripheral access.
  assign start = !z80_iorq_n && z80_m1_n && (!z80_rd_n || !z80_wr_n);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      z80_wait_n   <= 1'b1;
      z80_rdata    <= 8'h00;
      z80_rdata_en <= 1'b0;
      bus_valid    <= 1'b0;
      bus_write    <= 1'b0;
      bus_ioreq    <= 1'b0;
      bus_address  <= 8'h00;
      bus_wdata    <= 8'h00;
      timeout_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bus_address <= z80_address;
            bus_wdata   <= z80_wdata;
            bus_write   <= !z80_wr_n;
            bus_valid   <= 1'b1;
            bus_ioreq   <= 1'b1;
            z80_wait_n  <= 1'b0;
            state       <= REQ;
          end
        end
        REQ: begin
          if (z80_iorq_n) begin
            bus_valid  <= 1'b0;
            bus_ioreq  <= 1'b0;
            z80_wait_n <= 1'b1;
            state      <= IDLE;
          end else if (bus_ready) begin
            bus_valid <= 1'b0;
            bus_ioreq <= 1'b0;
            if (bus_write) begin
              z80_wait_n <= 1'b1;
              state      <= HOLD;
            end else begin
              timeout_cnt <= '0;
              state       <= RDWAIT;
            end
          end
        end
        RDWAIT: begin
          if (z80_iorq_n) begin
            z80_wait_n <= 1'b1;
            state      <= IDLE;
          end else if (bus_rdata_en) begin
            // Data takes priority over a timeout landing in the same cycle.
            z80_rdata    <= bus_rdata;
            z80_rdata_en <= 1'b1;
            z80_wait_n   <= 1'b1;
            state        <= HOLD;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            z80_rdata    <= OPEN_BUS_DATA;
            z80_rdata_en <= 1'b1;
            z80_wait_n   <= 1'b1;
            state        <= HOLD;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        HOLD: begin
          // Leaving only on IORQ high keeps a stretched IORQ from retriggering.
          if (z80_iorq_n) begin
            z80_rdata_en <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_io_bus_initiator.sv
// Directed stimulus with a scoreboard monitor for z80_io_bus_initiator.
module tb_z80_io_bus_initiator;

  logic       clk = 1'b0;
  logic       reset;
  logic       z80_iorq_n, z80_rd_n, z80_wr_n, z80_m1_n;
  logic [7:0] z80_address, z80_wdata;
  logic       z80_wait_n;
  logic [7:0] z80_rdata;
  logic       z80_rdata_en;
  logic       bus_ioreq;
  logic [7:0] bus_address;
  logic       bus_write;
  logic       bus_valid;
  logic       bus_ready;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_rdata_en;

  always #5 clk = ~clk;

  z80_io_bus_initiator dut (
    .clk          (clk),
    .reset        (reset),
    .z80_iorq_n   (z80_iorq_n),
    .z80_rd_n     (z80_rd_n),
    .z80_wr_n     (z80_wr_n),
    .z80_m1_n     (z80_m1_n),
    .z80_address  (z80_address),
    .z80_wdata    (z80_wdata),
    .z80_wait_n   (z80_wait_n),
    .z80_rdata    (z80_rdata),
    .z80_rdata_en (z80_rdata_en),
    .bus_ioreq    (bus_ioreq),
    .bus_address  (bus_address),
    .bus_write    (bus_write),
    .bus_valid    (bus_valid),
    .bus_ready    (bus_ready),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_rdata_en (bus_rdata_en)
  );

  // Output snapshot layout: wait_n, rdata_en, rdata, valid, write, ioreq, address, wdata.
  typedef struct packed {
    logic [28:0] mask;
    logic [28:0] val;
  } snap_t;

  localparam logic [28:0] F_WAIT  = 29'h1000_0000;
  localparam logic [28:0] F_RDEN  = 29'h0800_0000;
  localparam logic [28:0] F_RDATA = 29'h07F8_0000;
  localparam logic [28:0] F_VALID = 29'h0004_0000;
  localparam logic [28:0] F_IOREQ = 29'h0001_0000;
  localparam logic [28:0] M_ALL   = 29'h1FFF_FFFF;
  localparam logic [28:0] M_Z80   = F_WAIT | F_RDEN | F_RDATA | F_VALID;
  localparam logic [28:0] M_CTL   = F_WAIT | F_RDEN | F_VALID | F_IOREQ;
  localparam logic [28:0] RST_VAL = {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};

  logic [28:0] out_vec;
  assign out_vec = {z80_wait_n, z80_rdata_en, z80_rdata, bus_valid, bus_write,
                    bus_ioreq, bus_address, bus_wdata};

  logic [17:0] exp_beat[$];   // {ioreq, write, address, wdata}
  logic [7:0]  exp_rd[$];
  int          exp_wait[$];   // length of each WAIT-low run
  snap_t       exp_snap[$];

  int         tgt_busy  = 0;
  int         tgt_delay = 1;  // 0 = target never answers
  logic [7:0] tgt_data  = 8'h00;
  logic       done      = 1'b0;

  int checks = 0;
  int errors = 0;

  function automatic logic [28:0] zv(input logic w, input logic rden,
                                     input logic [7:0] rd, input logic v);
    return {w, rden, rd, v, 18'h0};
  endfunction

  task automatic push_snap(input logic [28:0] m, input logic [28:0] v);
    snap_t s;
    s.mask = m;
    s.val  = v;
    exp_snap.push_back(s);
  endtask

  // Target model: optional busy cycles, then a read-data pulse tgt_delay cycles after accept.
  initial begin
    int busy_left = 0;
    int pulse_in  = 0;
    bit seen      = 0;
    bus_ready    = 1'b1;
    bus_rdata_en = 1'b0;
    bus_rdata    = 8'h00;
    forever begin
      @(negedge clk);
      bus_rdata_en = 1'b0;
      bus_rdata    = 8'h00;
      if (pulse_in > 0) begin
        pulse_in--;
        if (pulse_in == 0) begin
          bus_rdata_en = 1'b1;
          bus_rdata    = tgt_data;
        end
      end
      if (reset) begin
        seen      = 0;
        bus_ready = 1'b1;
      end else if (bus_valid) begin
        if (!seen) begin
          seen      = 1;
          busy_left = tgt_busy;
        end
        if (busy_left > 0) begin
          bus_ready = 1'b0;
          busy_left--;
        end else begin
          bus_ready = 1'b1;
          seen      = 0;
          if (!bus_write && tgt_delay > 0) pulse_in = tgt_delay;
        end
      end else begin
        bus_ready = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations as the DUT presents beats, read data and WAIT releases.
  initial begin
    int   wait_run  = 0;
    logic prev_rden = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      while (exp_snap.size() > 0) begin
        snap_t s;
        s = exp_snap.pop_front();
        chk("snapshot", 32'(out_vec & s.mask), 32'(s.val & s.mask));
      end
      if (bus_valid) begin
        chk("beat_pending", 32'(exp_beat.size() != 0), 32'd1);
        if (exp_beat.size() != 0) begin
          chk("beat_fields", 32'({bus_ioreq, bus_write, bus_address, bus_wdata}),
              32'(exp_beat[0]));
          if (bus_ready) void'(exp_beat.pop_front());
        end
      end
      if (z80_rdata_en && !prev_rden) begin
        chk("rd_pending", 32'(exp_rd.size() != 0), 32'd1);
        chk("rd_wait_n", 32'(z80_wait_n), 32'd1);
        if (exp_rd.size() != 0) chk("rd_data", 32'(z80_rdata), 32'(exp_rd.pop_front()));
      end
      prev_rden = z80_rdata_en;
      if (!z80_wait_n) begin
        wait_run++;
      end else if (wait_run > 0) begin
        chk("wait_pending", 32'(exp_wait.size() != 0), 32'd1);
        if (exp_wait.size() != 0) chk("wait_len", 32'(wait_run), 32'(exp_wait.pop_front()));
        wait_run = 0;
      end
      if (done) begin
        chk("leftover_beats", 32'(exp_beat.size()), 32'd0);
        chk("leftover_reads", 32'(exp_rd.size()), 32'd0);
        chk("leftover_waits", 32'(exp_wait.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // kind: 0 = read, 1 = write, 2 = RD and WR both low
  task automatic io_start(input logic [7:0] a, input logic [7:0] d, input int kind);
    @(negedge clk);
    z80_address = a;
    z80_wdata   = d;
    z80_iorq_n  = 1'b0;
    z80_rd_n    = (kind == 1);
    z80_wr_n    = (kind == 0);
  endtask

  task automatic io_end();
    @(negedge clk);
    z80_iorq_n = 1'b1;
    z80_rd_n   = 1'b1;
    z80_wr_n   = 1'b1;
    z80_m1_n   = 1'b1;
  endtask

  task automatic wait_done();
    int n = 0;
    forever begin
      @(negedge clk);
      #2;
      if (z80_wait_n) break;
      n++;
      if (n > 400) begin
        $display("FAIL wait_release: z80_wait_n still 0 after %0d cycles", n);
        $fatal(1);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset       = 1'b1;
    z80_iorq_n  = 1'b1;
    z80_rd_n    = 1'b1;
    z80_wr_n    = 1'b1;
    z80_m1_n    = 1'b1;
    z80_address = 8'h00;
    z80_wdata   = 8'h00;
    idle(3);
    push_snap(M_ALL, RST_VAL);
    reset = 1'b0;
    idle(2);

    // OUT (C0h),5Ah: one beat, one WAIT cycle, no read data
    exp_beat.push_back({1'b1, 1'b1, 8'hC0, 8'h5A});
    exp_wait.push_back(1);
    io_start(8'hC0, 8'h5A, 1);
    wait_done();
    idle(3);
    io_end();
    @(negedge clk);
    push_snap(M_CTL, zv(1'b1, 1'b0, 8'h00, 1'b0));
    idle(2);

    // IN (C1h), single-cycle target: exact latency N+3
    tgt_data = 8'h3C;
    exp_beat.push_back({1'b1, 1'b0, 8'hC1, 8'h11});
    exp_rd.push_back(8'h3C);
    exp_wait.push_back(2);
    io_start(8'hC1, 8'h11, 0);
    idle(2);
    push_snap(F_WAIT | F_RDEN, zv(1'b0, 1'b0, 8'h00, 1'b0));
    @(negedge clk);
    push_snap(M_Z80, zv(1'b1, 1'b1, 8'h3C, 1'b0));
    idle(4);
    push_snap(M_Z80, zv(1'b1, 1'b1, 8'h3C, 1'b0));
    io_end();
    @(negedge clk);
    push_snap(F_WAIT | F_RDEN, zv(1'b1, 1'b0, 8'h00, 1'b0));
    idle(2);

    // IN (C3h), target busy for 3 cycles
    tgt_busy = 3;
    tgt_data = 8'h77;
    exp_beat.push_back({1'b1, 1'b0, 8'hC3, 8'h00});
    exp_rd.push_back(8'h77);
    exp_wait.push_back(5);
    io_start(8'hC3, 8'h00, 0);
    wait_done();
    idle(2);
    io_end();
    idle(2);

    // OUT (C7h),0Fh with busy target
    tgt_busy = 2;
    exp_beat.push_back({1'b1, 1'b1, 8'hC7, 8'h0F});
    exp_wait.push_back(3);
    io_start(8'hC7, 8'h0F, 1);
    wait_done();
    io_end();
    idle(2);
    tgt_busy = 0;

    // RD and WR both low is a write
    exp_beat.push_back({1'b1, 1'b1, 8'hD0, 8'h44});
    exp_wait.push_back(1);
    io_start(8'hD0, 8'h44, 2);
    wait_done();
    io_end();
    idle(2);

    // Timeout: no answer within 255 cycles, late pulse afterwards is ignored
    tgt_delay = 300;
    tgt_data  = 8'hA5;
    exp_beat.push_back({1'b1, 1'b0, 8'hC4, 8'h22});
    exp_rd.push_back(8'hFF);
    exp_wait.push_back(256);
    io_start(8'hC4, 8'h22, 0);
    wait_done();
    idle(60);
    push_snap(M_Z80, zv(1'b1, 1'b1, 8'hFF, 1'b0));
    io_end();
    idle(2);
    tgt_delay = 1;

    // Interrupt acknowledge: M1 with IORQ, no transaction
    @(negedge clk);
    z80_address = 8'hC5;
    z80_m1_n    = 1'b0;
    z80_iorq_n  = 1'b0;
    z80_rd_n    = 1'b0;
    idle(5);
    push_snap(M_CTL, zv(1'b1, 1'b0, 8'h00, 1'b0));
    io_end();
    idle(2);

    // Long IORQ after a completed write must not retrigger
    exp_beat.push_back({1'b1, 1'b1, 8'hC6, 8'h99});
    exp_wait.push_back(1);
    io_start(8'hC6, 8'h99, 1);
    wait_done();
    idle(20);
    push_snap(M_CTL, zv(1'b1, 1'b0, 8'h00, 1'b0));
    io_end();
    idle(2);

    // Reset while waiting for read data, then a clean IN (C2h)
    tgt_delay = 20;
    tgt_data  = 8'hEE;
    exp_beat.push_back({1'b1, 1'b0, 8'hC8, 8'h33});
    exp_wait.push_back(2);
    io_start(8'hC8, 8'h33, 0);
    idle(2);
    reset = 1'b1;
    @(negedge clk);
    push_snap(M_ALL, RST_VAL);
    reset      = 1'b0;
    z80_iorq_n = 1'b1;
    z80_rd_n   = 1'b1;
    idle(25);
    push_snap(M_Z80, zv(1'b1, 1'b0, 8'h00, 1'b0));
    tgt_delay = 1;
    tgt_data  = 8'h81;
    exp_beat.push_back({1'b1, 1'b0, 8'hC2, 8'h00});
    exp_rd.push_back(8'h81);
    exp_wait.push_back(2);
    io_start(8'hC2, 8'h00, 0);
    wait_done();
    idle(2);
    push_snap(M_Z80, zv(1'b1, 1'b1, 8'h81, 1'b0));
    io_end();
    idle(5);
    done = 1'b1;
  end

endmodule
